fifo_word_packer: RTL and testbench



---
 rtl/fifo_word_packer.sv | 158 +++++++++++++++
 tb/tb_fifo_word_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains bytes from a synchronous FIFO (registered read
// data, one cycle after read_enable) and packs WORD_BYTES of them into one
// output word on a valid/ready handshake. A flush pulse emits a partially
// filled word, zero-padded above the valid bytes, with its byte count.
module fifo_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int DW         = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fifo_empty,
  output logic                                fifo_rd_en,
  input  logic [DW-1:0]                       fifo_rd_data,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DW*WORD_BYTES-1:0]            out_data,
  output logic [$clog2(WORD_BYTES+1)-1:0]     out_cnt,
  output logic                                busy
);

  localparam int W  = DW * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WORD_BYTES);

  // FILL: normal packing. FLUSH: a flush is pending; reads are held off
  // until the in-flight byte lands and the partial word goes out.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          state_reg,      state_next;
  logic [CW-1:0]   issued_reg,     issued_next;
  logic [CW-1:0]   fill_cnt_reg,   fill_cnt_next;
  logic            rd_pending_reg, rd_pending_next;
  logic [W-1:0]    acc_reg,        acc_next;
  logic            out_valid_reg,  out_valid_next;
  logic [W-1:0]    out_data_reg,   out_data_next;
  logic [CW-1:0]   out_cnt_reg,    out_cnt_next;

  logic [W-1:0]    acc_capt;    // accumulator with the arriving byte merged in
  logic [W-1:0]    acc_masked;  // accumulator with unfilled lanes zeroed
  logic            flush_pend;
  logic            word_full;
  logic            flush_ready;
  logic            out_free;
  logic            transfer;

  assign flush_pend = (state_reg == ST_FLUSH);

  // Reads are only requested when the FIFO has data, so every request is
  // accepted; issued caps the number of bytes in flight plus buffered.
  assign fifo_rd_en = !rst && !fifo_empty && (issued_reg < FULL_CNT) && !flush_pend;

  assign word_full   = (fill_cnt_reg == FULL_CNT);
  assign flush_ready = flush_pend && !rd_pending_reg && (fill_cnt_reg != '0);
  assign out_free    = !out_valid_reg || out_ready;
  assign transfer    = (word_full || flush_ready) && out_free;

  // Per-lane capture steering and zero-padding of lanes beyond fill_cnt.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign acc_capt[gi*DW +: DW] =
        (rd_pending_reg && (fill_cnt_reg == CW'(gi))) ? fifo_rd_data : acc_reg[gi*DW +: DW];
      assign acc_masked[gi*DW +: DW] =
        (CW'(gi) < fill_cnt_reg) ? acc_reg[gi*DW +: DW] : '0;
    end
  endgenerate

  // Next-state logic: read issue, byte capture, word transfer, handshake
  // and the FILL/FLUSH state.
  always_comb begin
    state_next      = state_reg;
    issued_next     = issued_reg;
    fill_cnt_next   = fill_cnt_reg;
    rd_pending_next = fifo_rd_en;
    acc_next        = acc_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_cnt_next    = out_cnt_reg;

    // A transfer only happens when no read is being issued (issued is at
    // its cap or a flush holds reads off), so the two never collide.
    if (transfer) begin
      issued_next = '0;
    end else if (fifo_rd_en) begin
      issued_next = issued_reg + 1'b1;
    end

    // A capture cannot coincide with a transfer: a full word has no byte
    // in flight and a flush transfer waits for rd_pending to drop.
    if (transfer) begin
      acc_next      = '0;
      fill_cnt_next = '0;
    end else if (rd_pending_reg) begin
      acc_next      = acc_capt;
      fill_cnt_next = fill_cnt_reg + 1'b1;
    end

    if (transfer) begin
      out_valid_next = 1'b1;
      out_data_next  = acc_masked;
      out_cnt_next   = fill_cnt_reg;
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    // Leaving FLUSH (transfer, or nothing buffered) takes priority over a
    // new flush pulse, so a flush landing on a full word is absorbed by it.
    case (state_reg)
      ST_FILL: begin
        if (transfer) begin
          state_next = ST_FILL;
        end else if (flush) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (transfer || ((fill_cnt_reg == '0) && !rd_pending_reg)) begin
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // State registers with synchronous reset; any pending output word and
  // any byte still in flight are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FILL;
      issued_reg     <= '0;
      fill_cnt_reg   <= '0;
      rd_pending_reg <= 1'b0;
      acc_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      issued_reg     <= issued_next;
      fill_cnt_reg   <= fill_cnt_next;
      rd_pending_reg <= rd_pending_next;
      acc_reg        <= acc_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_cnt_reg    <= out_cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_cnt   = out_cnt_reg;
  assign busy      = (fill_cnt_reg != '0) || rd_pending_reg || flush_pend;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed testbench for fifo_word_packer: a byte FIFO model with
// registered read data feeds the packer; a negedge monitor logs accepted
// words, out_valid rises and read activity for the directed checks.
module tb_fifo_word_packer;

  localparam int WB = 4;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(.WORD_BYTES(WB), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_cnt      (out_cnt),
    .busy         (busy)
  );

  // FIFO model: written by the stimulus, popped on accepted reads with
  // data registered one cycle later.
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int empty_reads = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) empty_reads <= empty_reads + 1;
      fifo_rd_data <= mem[rd_ptr % 256];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Monitor, sampled mid-cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] w_data [64];
  logic [2:0]  w_cnt  [64];
  int word_n = 0;
  int rise_cyc [64];
  int rise_n = 0;
  int rdr_cyc [64];
  int rdr_n = 0;
  int rd_cnt = 0;
  int valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready && word_n < 64) begin
      w_data[word_n] = out_data;
      w_cnt[word_n]  = out_cnt;
      word_n = word_n + 1;
    end
    if (out_valid && !prev_valid && rise_n < 64) begin
      rise_cyc[rise_n] = cyc;
      rise_n = rise_n + 1;
    end
    if (fifo_rd_en && !prev_rd && rdr_n < 64) begin
      rdr_cyc[rdr_n] = cyc;
      rdr_n = rdr_n + 1;
    end
    if (fifo_rd_en) rd_cnt = rd_cnt + 1;
    if (out_valid) valid_cyc = valid_cyc + 1;
    prev_valid = out_valid;
    prev_rd    = fifo_rd_en;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int w0, rs0, rr0, rc0, vc0, r0;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    tick(1);

    // Single full word
    w0 = word_n; rs0 = rise_n; rr0 = rdr_n; rc0 = rd_cnt; vc0 = valid_cyc;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(12);
    $display("[TB] single word: %0d word(s), data 0x%08h cnt %0d", word_n - w0, w_data[w0], w_cnt[w0]);
    check("t1_rd_cycles", rd_cnt - rc0, 4);
    check("t1_word_count", word_n - w0, 1);
    check("t1_data", w_data[w0], 32'h44332211);
    check("t1_cnt", w_cnt[w0], 4);
    check("t1_valid_cycles", valid_cyc - vc0, 1);
    check("t1_latency", rise_cyc[rs0] - rdr_cyc[rr0], 6);
    check("t1_fifo_empty", fifo_empty, 1);
    check("t1_busy", busy, 0);

    // Streaming 16 bytes
    w0 = word_n; rs0 = rise_n;
    for (int i = 0; i < 16; i++) push(8'(i));
    tick(30);
    check("t2_word_count", word_n - w0, 4);
    for (int k = 0; k < 4; k++) begin
      $display("[TB] stream word %0d: data 0x%08h cnt %0d", k, w_data[w0 + k], w_cnt[w0 + k]);
      check("t2_data", w_data[w0 + k], {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      check("t2_cnt", w_cnt[w0 + k], 4);
    end
    for (int k = 0; k < 3; k++) check("t2_spacing", rise_cyc[rs0 + k + 1] - rise_cyc[rs0 + k], 6);

    // Back-pressure: 12 bytes, sink stalled for 20 cycles
    w0 = word_n;
    out_ready = 1'b0;
    r0 = rd_ptr;
    for (int i = 0; i < 12; i++) push(8'(8'h50 + i));
    tick(8);
    check("t3_valid_early", out_valid, 1);
    for (int i = 0; i < 12; i++) begin
      check("t3_hold_data", out_data, 32'h53525150);
      tick(1);
    end
    check("t3_valid_stall", out_valid, 1);
    check("t3_hold_cnt", out_cnt, 4);
    check("t3_stall_reads", rd_ptr - r0, 8);
    check("t3_busy", busy, 1);
    out_ready = 1'b1;
    tick(20);
    check("t3_word_count", word_n - w0, 3);
    for (int k = 0; k < 3; k++) begin
      $display("[TB] backpressure word %0d: data 0x%08h cnt %0d", k, w_data[w0 + k], w_cnt[w0 + k]);
      check("t3_data", w_data[w0 + k], {8'(8'h50+4*k+3), 8'(8'h50+4*k+2), 8'(8'h50+4*k+1), 8'(8'h50+4*k)});
      check("t3_cnt", w_cnt[w0 + k], 4);
    end

    // Partial flush
    w0 = word_n;
    push(8'hAA); push(8'hBB);
    tick(4);
    check("t4_busy_before", busy, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    $display("[TB] partial flush: data 0x%08h cnt %0d", w_data[w0], w_cnt[w0]);
    check("t4_word_count", word_n - w0, 1);
    check("t4_data", w_data[w0], 32'h0000BBAA);
    check("t4_cnt", w_cnt[w0], 2);
    check("t4_busy_after", busy, 0);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    tick(10);
    $display("[TB] after flush: data 0x%08h cnt %0d", w_data[w0 + 1], w_cnt[w0 + 1]);
    check("t4_next_data", w_data[w0 + 1], 32'h04030201);
    check("t4_next_cnt", w_cnt[w0 + 1], 4);

    // Flush with an empty accumulator
    w0 = word_n;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t5_busy_pend", busy, 1);
    tick(1);
    check("t5_busy_clear", busy, 0);
    tick(3);
    $display("[TB] empty flush: %0d word(s)", word_n - w0);
    check("t5_no_word", word_n - w0, 0);

    // Flush on the cycle the 4th byte is captured
    w0 = word_n;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    tick(4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(8);
    $display("[TB] flush at completion: %0d word(s), data 0x%08h cnt %0d", word_n - w0, w_data[w0], w_cnt[w0]);
    check("t6_word_count", word_n - w0, 1);
    check("t6_data", w_data[w0], 32'hC4C3C2C1);
    check("t6_cnt", w_cnt[w0], 4);
    check("t6_busy", busy, 0);

    // Reset mid-word
    w0 = word_n;
    push(8'h99); push(8'h98);
    tick(3);
    check("t7_busy_mid", busy, 1);
    rst = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    #1;
    check("t7_rd_en_in_rst", fifo_rd_en, 0);
    tick(1);
    check("t7_valid_rst", out_valid, 0);
    check("t7_busy_rst", busy, 0);
    check("t7_rd_en_rst", fifo_rd_en, 0);
    rst = 1'b0;
    tick(12);
    $display("[TB] after reset: %0d word(s), data 0x%08h cnt %0d", word_n - w0, w_data[w0], w_cnt[w0]);
    check("t7_word_count", word_n - w0, 1);
    check("t7_data", w_data[w0], 32'hDDCCBBAA);
    check("t7_cnt", w_cnt[w0], 4);

    // Global FIFO-side checks
    check("no_empty_reads", empty_reads, 0);
    check("fifo_drained", rd_ptr, wr_ptr);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
